ps2_key_sequencer: RTL and testbench

//  Decodes the PS/2 byte stream (received_data/received_data_en from PS2_Controller) into

---
 rtl/ps2_key_sequencer_pkg.sv | 33 +++
 rtl/ps2_key_sequencer_if.sv | 22 ++
 rtl/ps2_key_sequencer_seq_timeout.sv | 30 +++
 rtl/ps2_key_sequencer.sv | 111 +++++++++++
 tb/tb_ps2_key_sequencer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/ps2_key_sequencer_pkg.sv
// Shared PS/2 scan, prefix and error codes, plus the key sequencer state encoding.
package ps2_key_sequencer_pkg;

   localparam logic [7:0] CODE_BREAK     = 8'hF0;
   localparam logic [7:0] CODE_EXT       = 8'hE0;
   localparam logic [7:0] CODE_BAT_OK    = 8'hAA;
   localparam logic [7:0] CODE_ACK       = 8'hFA;
   localparam logic [7:0] CODE_ECHO      = 8'hEE;
   localparam logic [7:0] CODE_ERR_00    = 8'h00;
   localparam logic [7:0] CODE_BAT_FAIL  = 8'hFC;
   localparam logic [7:0] CODE_BAT_FAIL2 = 8'hFD;
   localparam logic [7:0] CODE_ERR_FF    = 8'hFF;
   localparam logic [7:0] CODE_HIT       = 8'h33;
   localparam logic [7:0] CODE_STAND     = 8'h1B;
   localparam logic [7:0] CODE_DEAL      = 8'h23;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } seq_state_e;

   function automatic logic is_error_code(input logic [7:0] c);
      return (c == CODE_ERR_00) || (c == CODE_BAT_FAIL) ||
             (c == CODE_BAT_FAIL2) || (c == CODE_ERR_FF);
   endfunction

   function automatic logic is_status_code(input logic [7:0] c);
      return (c == CODE_BAT_OK) || (c == CODE_ACK) || (c == CODE_ECHO);
   endfunction

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Byte-stream input and action-event outputs of the PS/2 key sequencer.
interface ps2_key_sequencer_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       game_ready;
   logic       hit_pressed;
   logic       stand_pressed;
   logic       deal_pressed;
   logic [2:0] key_held;
   logic [7:0] last_code;
   logic       seq_error;

   modport master (
      output rx_data, rx_valid, game_ready,
      input  hit_pressed, stand_pressed, deal_pressed, key_held, last_code, seq_error
   );

   modport slave (
      input  rx_data, rx_valid, game_ready,
      output hit_pressed, stand_pressed, deal_pressed, key_held, last_code, seq_error
   );
endinterface

// File: rtl/ps2_key_sequencer_seq_timeout.sv
// Saturating inactivity timer; expire_o is high in the terminal count cycle when not cleared.
module ps2_seq_timeout #(
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam int unsigned TW = ($clog2(TIMEOUT_CYC) < 1) ? 1 : $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] timer_q, timer_d;

   always_comb begin
      timer_d = timer_q;
      if (clr_i)
         timer_d = '0;
      else if (en_i && (timer_q != LAST))
         timer_d = timer_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) timer_q <= '0;
      else         timer_q <= timer_d;
   end

   assign expire_o = en_i && !clr_i && (timer_q == LAST);
endmodule

// File: rtl/ps2_key_sequencer.sv
// Turns the PS/2 byte stream into one-shot hit/stand/deal events with prefix tracking,
// typematic-repeat suppression and stale-sequence abort.
module ps2_key_sequencer
   import ps2_key_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 50000,
   parameter logic [7:0]  HIT_CODE    = CODE_HIT,
   parameter logic [7:0]  STAND_CODE  = CODE_STAND,
   parameter logic [7:0]  DEAL_CODE   = CODE_DEAL
) (
   input logic                 CLOCK_50,
   input logic                 resetn,
   ps2_key_sequencer_if.slave  bus
);
   seq_state_e state_q, state_d;
   logic [2:0] held_q, held_d;
   logic [7:0] last_q, last_d;
   logic       hit_q, hit_d, stand_q, stand_d, deal_q, deal_d, err_q, err_d;
   logic       timer_clr, timer_en, expire;

   assign timer_clr = bus.rx_valid || (state_q == ST_IDLE);
   assign timer_en  = (state_q != ST_IDLE);

   ps2_seq_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk_i    (CLOCK_50),
      .rst_ni   (resetn),
      .clr_i    (timer_clr),
      .en_i     (timer_en),
      .expire_o (expire)
   );

   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      last_d  = last_q;
      hit_d   = 1'b0;
      stand_d = 1'b0;
      deal_d  = 1'b0;
      err_d   = 1'b0;
      if (bus.rx_valid) begin
         if (is_error_code(bus.rx_data)) begin
            held_d  = '0;
            state_d = ST_IDLE;
            err_d   = 1'b1;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (bus.rx_data == CODE_BREAK) begin
                     state_d = ST_BRK;
                  end else if (bus.rx_data == CODE_EXT) begin
                     state_d = ST_EXT;
                  end else if (!is_status_code(bus.rx_data)) begin
                     last_d = bus.rx_data;
                     // A set held bit marks a typematic repeat; game_ready only gates the pulse.
                     if (bus.rx_data == HIT_CODE && !held_q[0]) begin
                        held_d[0] = 1'b1;
                        hit_d     = bus.game_ready;
                     end else if (bus.rx_data == STAND_CODE && !held_q[1]) begin
                        held_d[1] = 1'b1;
                        stand_d   = bus.game_ready;
                     end else if (bus.rx_data == DEAL_CODE && !held_q[2]) begin
                        held_d[2] = 1'b1;
                        deal_d    = bus.game_ready;
                     end
                  end
               end
               ST_EXT:     state_d = (bus.rx_data == CODE_BREAK) ? ST_EXT_BRK : ST_IDLE;
               ST_BRK: begin
                  last_d  = bus.rx_data;
                  state_d = ST_IDLE;
                  if (bus.rx_data == HIT_CODE)   held_d[0] = 1'b0;
                  if (bus.rx_data == STAND_CODE) held_d[1] = 1'b0;
                  if (bus.rx_data == DEAL_CODE)  held_d[2] = 1'b0;
               end
               ST_EXT_BRK: state_d = ST_IDLE;
               default:    state_d = ST_IDLE;
            endcase
         end
      end else if (expire) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         held_q  <= '0;
         last_q  <= '0;
         hit_q   <= 1'b0;
         stand_q <= 1'b0;
         deal_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         last_q  <= last_d;
         hit_q   <= hit_d;
         stand_q <= stand_d;
         deal_q  <= deal_d;
         err_q   <= err_d;
      end
   end

   assign bus.hit_pressed   = hit_q;
   assign bus.stand_pressed = stand_q;
   assign bus.deal_pressed  = deal_q;
   assign bus.key_held      = held_q;
   assign bus.last_code     = last_q;
   assign bus.seq_error     = err_q;
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer with a short timeout so the abort path is reachable.
module tb_ps2_key_sequencer;
   localparam int unsigned TO = 16;

   logic clk = 1'b0;
   logic resetn;
   int   n_checks = 0;
   int   n_errors = 0;

   ps2_key_sequencer_if bus();

   ps2_key_sequencer #(.TIMEOUT_CYC(TO)) dut (
      .CLOCK_50 (clk),
      .resetn   (resetn),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] pulses();
      return {bus.deal_pressed, bus.stand_pressed, bus.hit_pressed};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Outputs sampled on return reflect the byte just sent.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   initial begin
      int err_cnt;
      int err_at;
      bus.rx_data    = '0;
      bus.rx_valid   = 1'b0;
      bus.game_ready = 1'b1;
      resetn         = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", {pulses(), bus.key_held, bus.last_code, bus.seq_error}, '0);
      resetn = 1'b1;

      send_byte(8'h33);
      check("t1_hit_pulse", pulses(), 3'b001);
      check("t1_held", bus.key_held, 3'b001);
      @(negedge clk);
      check("t1_pulse_1cyc", pulses(), 3'b000);

      send_byte(8'h33);
      check("t2_rep1", pulses(), 3'b000);
      send_byte(8'h33);
      check("t2_rep2", pulses(), 3'b000);
      send_byte(8'hF0);
      check("t2_f0_nopulse", pulses(), 3'b000);
      send_byte(8'h33);
      check("t2_held_clr", bus.key_held, 3'b000);
      check("t2_last", bus.last_code, 8'h33);
      check("t2_noerr", bus.seq_error, 1'b0);

      send_byte(8'hE0);
      send_byte(8'h1B);
      check("t3_ext_make", {pulses(), bus.key_held}, '0);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h1B);
      check("t3_ext_brk", {pulses(), bus.key_held, bus.seq_error}, '0);
      send_byte(8'h1B);
      check("t3_idle_make", pulses(), 3'b010);
      send_byte(8'hF0);
      send_byte(8'h1B);
      check("t3_rel", bus.key_held, 3'b000);

      send_byte(8'h33);
      send_byte(8'hF0);
      err_cnt = 0;
      err_at  = -1;
      for (int i = 0; i < int'(TO) + 6; i++) begin
         @(negedge clk);
         if (bus.seq_error) begin
            err_cnt++;
            if (err_at < 0) err_at = i;
         end
      end
      check("t4_timeout_cnt", err_cnt, 1);
      check("t4_timeout_at", err_at, TO - 1);
      check("t4_held_kept", bus.key_held, 3'b001);
      send_byte(8'h23);
      check("t4_deal_pulse", pulses(), 3'b100);
      check("t4_held", bus.key_held, 3'b101);
      send_byte(8'hF0);
      send_byte(8'h33);
      send_byte(8'hF0);
      send_byte(8'h23);
      check("t4_rel", bus.key_held, 3'b000);

      send_byte(8'hF0);
      repeat (TO - 2) @(negedge clk);
      send_byte(8'h23);
      check("t4b_terminal_byte", {pulses(), bus.seq_error}, '0);
      check("t4b_last", bus.last_code, 8'h23);
      send_byte(8'h23);
      check("t4b_idle_after", pulses(), 3'b100);
      send_byte(8'hF0);
      send_byte(8'h23);

      bus.game_ready = 1'b0;
      send_byte(8'h1B);
      check("t5_gated", pulses(), 3'b000);
      check("t5_held", bus.key_held, 3'b010);
      bus.game_ready = 1'b1;
      send_byte(8'h1B);
      check("t5_repeat", pulses(), 3'b000);
      send_byte(8'hF0);
      send_byte(8'h1B);
      check("t5_rel", bus.key_held, 3'b000);
      send_byte(8'h1B);
      check("t5_stand", pulses(), 3'b010);
      send_byte(8'hF0);
      send_byte(8'h1B);

      send_byte(8'h23);
      check("t6_deal", pulses(), 3'b100);
      send_byte(8'hFF);
      check("t6_err", bus.seq_error, 1'b1);
      check("t6_held_clr", bus.key_held, 3'b000);
      @(negedge clk);
      check("t6_err_1cyc", bus.seq_error, 1'b0);
      send_byte(8'h33);
      send_byte(8'hE0);
      send_byte(8'hF0);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("t6_async_rst", {pulses(), bus.key_held, bus.last_code, bus.seq_error}, '0);
      @(negedge clk);
      resetn = 1'b1;
      send_byte(8'h33);
      check("t6_post_rst_hit", pulses(), 3'b001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
